uart_rx_fifo_ctrl: RTL and testbench

//  Sequencer and buffer between the async UART receiver and the APB register file.
//  Per received character it does three things:
//  - captures the byte and its parity flag on the receiver's fifo_write strobe;
//  - attaches the framing flag at stop_strobe and commits the entry to a DEPTH-deep FIFO;
//  - pulses the receiver's clear_parity / clear_framing_error inputs.
//  It also raises overflow, level and (optionally) timeout interrupts.

---
 rtl/uart_rx_fifo_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: sequencer and buffer between the async UART receiver and
// the APB register file. It stages each received byte with its parity flag,
// attaches the framing flag at the end of the stop bit, and commits the entry
// to a DEPTH-deep first-word-fall-through FIFO. It also pulses the receiver's
// flag-clear inputs and raises the overflow, level and timeout interrupts.
// Optional feature: define RX_TIMEOUT_EN to build the inactivity timeout counter.
module uart_rx_fifo_ctrl #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned AFULL_LVL     = 12,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_clock,
  input  logic              fifo_write_n,
  input  logic [7:0]        rx_byte,
  input  logic              parity_err,
  input  logic              framing_error,
  input  logic              stop_strobe,
  input  logic              read_rx_byte,
  input  logic              flush,
  output logic              clear_parity,
  output logic              clear_framing_error,
  output logic [7:0]        rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              receive_full,
  output logic              fifo_full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              timeout_irq,
  output logic              irq
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LVL);

  typedef enum logic {IDLE, WAIT_STOP} state_t;

  state_t state, state_next;

  logic              strobe;
  logic              stage;
  logic              commit;
  logic              commit_ferr;
  logic              stop_seen;
  logic              wr_en;
  logic              pop;
  logic              full_next;

  logic [7:0]        pend_data;
  logic              pend_perr;
  logic              pend_keep;

  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic [ADDR_W:0]   count_next;

  assign strobe = ~fifo_write_n;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a write strobe always (re)enters WAIT_STOP
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (strobe) state_next = WAIT_STOP;
        WAIT_STOP: begin
          if (strobe)           state_next = WAIT_STOP;
          else if (stop_strobe) state_next = IDLE;
        end
        default:   state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: commit of the pending character, its framing flag, staging
  always_comb begin
    commit      = 1'b0;
    commit_ferr = 1'b0;
    stop_seen   = 1'b0;
    if (state == WAIT_STOP) begin
      if (stop_strobe) begin
        commit      = 1'b1;
        commit_ferr = framing_error;
        stop_seen   = 1'b1;
      end else if (strobe) begin
        // a new character arrived before the stop bit finished: frame is broken
        commit      = 1'b1;
        commit_ferr = 1'b1;
      end
    end
    stage = strobe & ~flush;
  end

  assign wr_en = commit & pend_keep & ~flush;
  assign pop   = read_rx_byte & (count != '0) & ~flush;

  // Occupancy and head pointer after this cycle's commit/pop
  always_comb begin
    count_next = count;
    unique case ({wr_en, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    rd_ptr_next = rd_ptr;
    if (pop) rd_ptr_next = rd_ptr + 1'b1;
  end

  // Full is judged after a same-cycle forced commit, so a later commit never hits a full FIFO
  assign full_next = (count_next == DEPTH_C);

  // Pending character register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_data <= '0;
      pend_perr <= 1'b0;
      pend_keep <= 1'b0;
    end else if (flush) begin
      pend_keep <= 1'b0;
    end else if (stage) begin
      pend_data <= rx_byte;
      pend_perr <= parity_err;
      pend_keep <= ~full_next;
    end else if (commit) begin
      pend_keep <= 1'b0;
    end
  end

  // One-clk clear pulses back to the receiver
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_parity        <= 1'b0;
      clear_framing_error <= 1'b0;
    end else begin
      clear_parity        <= stage;
      clear_framing_error <= stop_seen & ~flush;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {pend_data, pend_perr, commit_ferr};
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Registered head entry; bypasses the entry being written when it becomes the head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {rx_data, rx_perr, rx_ferr} <= '0;
    end else if (flush || count_next == '0) begin
      {rx_data, rx_perr, rx_ferr} <= '0;
    end else if (wr_en && wr_ptr == rd_ptr_next) begin
      {rx_data, rx_perr, rx_ferr} <= {pend_data, pend_perr, commit_ferr};
    end else begin
      {rx_data, rx_perr, rx_ferr} <= mem[rd_ptr_next];
    end
  end

  // Sticky overflow: flush beats a set, a set beats a read clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  overflow <= 1'b0;
    else if (flush)             overflow <= 1'b0;
    else if (stage & full_next) overflow <= 1'b1;
    else if (read_rx_byte)      overflow <= 1'b0;
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_TICKS);

  logic [TO_W-1:0] idle_cnt;

  // Inactivity counter in baud ticks while data waits in the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (flush || wr_en || pop || count == '0)
      idle_cnt <= '0;
    else if (baud_clock && idle_cnt != TO_LIM)
      idle_cnt <= idle_cnt + 1'b1;
  end

  // Sticky timeout flag, released by a pop or flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 timeout_irq <= 1'b0;
    else if (flush || pop)     timeout_irq <= 1'b0;
    else if (idle_cnt == TO_LIM) timeout_irq <= 1'b1;
  end
`else
  logic [32:0] timeout_unused;
  assign timeout_unused = {baud_clock, TIMEOUT_TICKS};
  assign timeout_irq    = 1'b0;
`endif

  assign receive_full = (count != '0);
  assign fifo_full    = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign irq          = almost_full | overflow | timeout_irq |
                        (receive_full & (rx_perr | rx_ferr));

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb_uart_rx_fifo_ctrl: scoreboard bench for uart_rx_fifo_ctrl. Stimulus tasks
// update a queue-based reference of the FIFO contents; a monitor pops and
// compares the head entry whenever a read is presented to the DUT.
module tb_uart_rx_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_clock = 1'b0;
  logic       fifo_write_n = 1'b1;
  logic [7:0] rx_byte = '0;
  logic       parity_err = 1'b0;
  logic       framing_error = 1'b0;
  logic       stop_strobe = 1'b0;
  logic       read_rx_byte = 1'b0;
  logic       flush = 1'b0;
  logic       clear_parity, clear_framing_error;
  logic [7:0] rx_data;
  logic       rx_perr, rx_ferr, receive_full, fifo_full, almost_full;
  logic [4:0] count;
  logic       overflow, timeout_irq, irq;

  uart_rx_fifo_ctrl #(
    .DEPTH(16), .ADDR_W(4), .AFULL_LVL(12), .TIMEOUT_TICKS(320)
  ) dut (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .fifo_write_n(fifo_write_n),
    .rx_byte(rx_byte), .parity_err(parity_err), .framing_error(framing_error),
    .stop_strobe(stop_strobe), .read_rx_byte(read_rx_byte), .flush(flush),
    .clear_parity(clear_parity), .clear_framing_error(clear_framing_error),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .receive_full(receive_full), .fifo_full(fifo_full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .timeout_irq(timeout_irq), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference: committed entries {data, perr, ferr}, oldest first
  logic [9:0] exp_q[$];
  logic       ovf_m = 1'b0;
  logic       m_pend = 1'b0;
  logic       m_keep = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_perr = 1'b0;
  int         cp_exp = 0, cf_exp = 0, cp_seen = 0, cf_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 8x baud enable: one clk wide, every 8 clks
  initial begin
    forever begin
      repeat (7) @(posedge clk);
      #1 baud_clock = 1'b1;
      @(posedge clk);
      #1 baud_clock = 1'b0;
    end
  end

  // pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (clear_parity) cp_seen++;
      if (clear_framing_error) cf_seen++;
    end
  end

  // scoreboard monitor: a read presents the head entry
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!reset && read_rx_byte && !flush) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pop.data", 32'(rx_data), 32'(e[9:2]));
          chk("pop.perr", 32'(rx_perr), 32'(e[1]));
          chk("pop.ferr", 32'(rx_ferr), 32'(e[0]));
        end else begin
          chk("empty_read.data", 32'(rx_data), 0);
          chk("empty_read.count", 32'(count), 0);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d, input logic p);
    tick();
    fifo_write_n = 1'b0;
    rx_byte      = d;
    parity_err   = p;
    tick();
    fifo_write_n = 1'b1;
    parity_err   = 1'b0;
    if (m_pend && m_keep) exp_q.push_back({m_data, m_perr, 1'b1});
    if (exp_q.size() == DEPTH) begin
      m_keep = 1'b0;
      ovf_m  = 1'b1;
    end else begin
      m_keep = 1'b1;
    end
    m_pend = 1'b1;
    m_data = d;
    m_perr = p;
    cp_exp++;
  endtask

  task automatic stop(input logic f);
    tick();
    stop_strobe   = 1'b1;
    framing_error = f;
    tick();
    stop_strobe   = 1'b0;
    framing_error = 1'b0;
    if (m_pend) begin
      if (m_keep) exp_q.push_back({m_data, m_perr, f});
      cf_exp++;
    end
    m_pend = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic f);
    strobe(d, p);
    tick();
    stop(f);
  endtask

  task automatic rd();
    tick();
    read_rx_byte = 1'b1;
    tick();
    read_rx_byte = 1'b0;
    ovf_m = 1'b0;
  endtask

  task automatic do_flush();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    ovf_m  = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [9:0] h;
    int n;
    logic irq_m;
    @(negedge clk);
    n = exp_q.size();
    h = (n > 0) ? exp_q[0] : 10'd0;
    irq_m = (n >= AFULL) || ovf_m || (n > 0 && (h[1] || h[0]));
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".receive_full"}, 32'(receive_full), 32'(n != 0));
    chk({tag, ".fifo_full"}, 32'(fifo_full), 32'(n == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AFULL));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    chk({tag, ".head"}, {22'd0, rx_data, rx_perr, rx_ferr}, {22'd0, h});
`ifndef RX_TIMEOUT_EN
    chk({tag, ".timeout_irq"}, 32'(timeout_irq), 0);
    chk({tag, ".irq"}, 32'(irq), 32'(irq_m));
`endif
  endtask

  task automatic check_pulses(input string tag);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, ".clear_parity_pulses"}, cp_seen, cp_exp);
    chk({tag, ".clear_framing_pulses"}, cf_seen, cf_exp);
  endtask

  initial begin
    int op;
    repeat (3) tick();
    check_state("reset");
    chk("reset.clear_parity", 32'(clear_parity), 0);
    chk("reset.clear_framing_error", 32'(clear_framing_error), 0);
    reset = 1'b0;

    // basic character
    strobe(8'h5A, 1'b0);
    repeat (2) tick();
    check_state("pending_invisible");
    stop(1'b0);
    check_state("t1");
    check_pulses("t1");
    rd();
    check_state("t1_pop");

    // fill to full, then overflow
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    check_state("t2_full");
    send(8'hFF, 1'b0, 1'b0);
    check_state("t2_overflow");
    rd();
    check_state("t2_first_read");
    for (int i = 1; i < 16; i++) rd();
    check_state("t2_drained");
    rd();
    check_state("t2_empty_read");

    // error flags at head
    send(8'h33, 1'b0, 1'b1);
    check_state("t3_ferr");
    rd();
    send(8'h44, 1'b1, 1'b0);
    check_state("t3_perr");
    rd();

    // second strobe before stop bit
    strobe(8'h11, 1'b0);
    tick();
    strobe(8'h22, 1'b0);
    check_state("t4_forced");
    stop(1'b0);
    check_state("t4_second");
    rd();
    rd();
    check_pulses("t4");

    // commit and pop together at count 15
    do_flush();
    for (int i = 0; i < 15; i++) send(8'(8'h80 + i), 1'b0, 1'b0);
    strobe(8'h77, 1'b0);
    tick();
    stop_strobe   = 1'b1;
    read_rx_byte  = 1'b1;
    tick();
    stop_strobe   = 1'b0;
    read_rx_byte  = 1'b0;
    exp_q.push_back({8'h77, 1'b0, 1'b0});
    cf_exp++;
    m_pend = 1'b0;
    ovf_m  = 1'b0;
    check_state("t5_commit_pop");

    // almost_full threshold, then flush mid-character
    do_flush();
    check_state("t5_flush");
    for (int i = 0; i < 11; i++) send(8'(8'hC0 + i), 1'b0, 1'b0);
    check_state("t5_eleven");
    send(8'hCB, 1'b0, 1'b0);
    check_state("t5_twelve");
    strobe(8'h55, 1'b0);
    do_flush();
    stop(1'b0);
    check_state("t5_flush_idle");
    check_pulses("t5");

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      op = int'($urandom_range(0, 99));
      if (m_pend && op < 55) begin
        stop(1'($urandom_range(0, 3) == 0));
      end else if (op < 80) begin
        strobe(8'($urandom), 1'($urandom_range(0, 3) == 0));
      end else if (op < 97) begin
        rd();
      end else begin
        do_flush();
      end
      check_state("rand");
    end
    if (m_pend) stop(1'b0);
    check_pulses("rand");

    // inactivity timeout
    do_flush();
    send(8'h99, 1'b0, 1'b0);
`ifdef RX_TIMEOUT_EN
    repeat (8 * 330) tick();
    @(negedge clk);
    chk("t6.timeout_set", 32'(timeout_irq), 1);
    chk("t6.irq", 32'(irq), 1);
    rd();
    @(negedge clk);
    chk("t6.timeout_cleared", 32'(timeout_irq), 0);
`else
    repeat (8 * 330) tick();
    check_state("t6_no_timeout");
    rd();
    check_state("t6_pop");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
